// File: rtl/sample_pwm_player_if.sv
// Producer-side sample handshake bundle for sample_pwm_player.
// The producer drives sample/valid and the player returns ready.
interface sample_pwm_player_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/sample_pwm_player.sv
// Buffered PCM-to-PWM audio player: a small sample FIFO feeding a
// duty register that is compared against a free-running carrier counter.
module sample_pwm_player #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     MHz10,
    input  logic                     nrst,
    input  logic                     en,
    input  logic                     samp_enable,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     pwm_out,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             pwm_out_q, pwm_out_d;
    logic             underrun_q, underrun_d;

    logic push;
    logic strobe;
    logic pop;

    assign sample_ready = (count_q < FULL);
    assign push         = sample_valid && sample_ready;
    assign strobe       = en && samp_enable;
    // Pop sees only the pre-edge count, so a same-cycle push is never bypassed.
    assign pop          = strobe && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = sample_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        duty_d   = duty_q;
        if (pop) begin
            duty_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            push && !pop: count_d = count_q + 1'b1;
            pop && !push: count_d = count_q - 1'b1;
            default:      count_d = count_q;
        endcase
    end

    always_comb begin
        underrun_d = strobe && (count_q == '0);
        pwm_cnt_d  = en ? pwm_cnt_q + 1'b1 : '0;
        pwm_out_d  = en && (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            duty_q     <= '0;
            pwm_cnt_q  <= '0;
            pwm_out_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_out_q  <= pwm_out_d;
            underrun_q <= underrun_d;
        end
    end

    assign pwm_out    = pwm_out_q;
    assign underrun   = underrun_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_sample_pwm_player.sv
// Directed plus randomized checks of sample_pwm_player against a
// queue-based reference model of the FIFO, strobe and duty rules.
module tb_sample_pwm_player;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       nrst;
    logic       en;
    logic       samp;
    logic       pwm_out;
    logic       underrun;
    logic [2:0] fifo_count;

    sample_pwm_player_if #(.WIDTH(WIDTH)) bus ();

    sample_pwm_player #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .MHz10        (clk),
        .nrst         (nrst),
        .en           (en),
        .samp_enable  (samp),
        .sample_in    (bus.sample_in),
        .sample_valid (bus.sample_valid),
        .sample_ready (bus.sample_ready),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] duty_m;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model advances on the edge, outputs checked at negedge.
    task automatic tick();
        int   n;
        logic psh, pop, urun;
        n    = q.size();
        psh  = bus.sample_valid && (n < DEPTH);
        pop  = en && samp && (n > 0);
        urun = en && samp && (n == 0);
        @(posedge clk);
        if (pop) duty_m = q.pop_front();
        if (psh) q.push_back(bus.sample_in);
        @(negedge clk);
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("sample_ready", 32'(bus.sample_ready), 32'(q.size() < DEPTH));
        chk("underrun", 32'(underrun), 32'(urun));
    endtask

    task automatic push1(input logic [WIDTH-1:0] v);
        bus.sample_in    = v;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic strobe1();
        samp = 1'b1;
        tick();
        samp = 1'b0;
    endtask

    // Count high cycles over one full carrier period.
    task automatic measure(input string tag, input int exp);
        int hi;
        hi = 0;
        en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 256; i++) begin
            tick();
            hi += int'(pwm_out);
        end
        chk(tag, 32'(hi), 32'(exp));
        chk({tag, "_model"}, 32'(hi), 32'(duty_m));
    endtask

    initial begin
        nrst             = 1'b0;
        en               = 1'b0;
        samp             = 1'b0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        duty_m           = '0;
        #12;
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(bus.sample_ready), 1);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_underrun", 32'(underrun), 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();

        push1(8'h80);
        push1(8'h40);
        push1(8'hFF);
        push1(8'h00);
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(bus.sample_ready), 0);
        bus.sample_in    = 8'h11;
        bus.sample_valid = 1'b1;
        tick();
        tick();
        chk("held_count", 32'(fifo_count), 4);

        en = 1'b1;
        strobe1();
        chk("pop_full_count", 32'(fifo_count), 3);
        tick();
        chk("held_accepted", 32'(fifo_count), 4);
        bus.sample_valid = 1'b0;
        measure("duty_80", 128);

        for (int i = 0; i < 4; i++) begin
            strobe1();
            tick();
        end
        chk("drained", 32'(fifo_count), 0);
        strobe1();
        chk("underrun_pulse", 32'(underrun), 1);
        tick();
        chk("underrun_one_cycle", 32'(underrun), 0);
        measure("duty_kept", 8'h11);

        bus.sample_in    = 8'h77;
        bus.sample_valid = 1'b1;
        samp             = 1'b1;
        tick();
        samp             = 1'b0;
        bus.sample_valid = 1'b0;
        chk("nobypass_urun", 32'(underrun), 1);
        chk("nobypass_count", 32'(fifo_count), 1);
        strobe1();
        push1(8'h20);
        push1(8'h30);
        bus.sample_in    = 8'h50;
        bus.sample_valid = 1'b1;
        samp             = 1'b1;
        tick();
        samp             = 1'b0;
        bus.sample_valid = 1'b0;
        chk("simul_count", 32'(fifo_count), 2);
        measure("duty_head", 8'h20);

        push1(8'hFF);
        for (int i = 0; i < 3; i++) strobe1();
        measure("duty_ff", 255);
        for (int i = 0; i < 37; i++) tick();
        en = 1'b0;
        tick();
        chk("en_low_pwm", 32'(pwm_out), 0);
        samp = 1'b1;
        tick();
        chk("en_low_no_urun", 32'(underrun), 0);
        push1(8'h40);
        samp = 1'b0;
        chk("en_low_push", 32'(fifo_count), 1);
        push1(8'h01);
        push1(8'h02);
        push1(8'h03);
        en = 1'b1;
        strobe1();
        for (int i = 0; i < 20; i++) tick();
        chk("pre_rst_count", 32'(fifo_count), 3);

        #2;
        nrst = 1'b0;
        #1;
        chk("async_count", 32'(fifo_count), 0);
        chk("async_pwm", 32'(pwm_out), 0);
        chk("async_ready", 32'(bus.sample_ready), 1);
        q.delete();
        duty_m = '0;
        en     = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.sample_ready), 1);
        measure("post_rst_duty0", 0);

        for (int i = 0; i < 400; i++) begin
            en               = ($urandom_range(0, 7) != 0);
            samp             = ($urandom_range(0, 3) == 0);
            bus.sample_valid = ($urandom_range(0, 2) == 0);
            bus.sample_in    = WIDTH'($urandom);
            tick();
        end
        samp             = 1'b0;
        bus.sample_valid = 1'b0;
        measure("rand_duty", int'(duty_m));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
